// File: rtl/uart_pkg.sv
// Shared state encoding and constants for the UART receive path.
package uart_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_DIV_W     = 16;
  localparam int MIN_DIV       = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: latches the clamped baud divisor at frame start and
// counts clocks within the current bit, flagging the half and full points.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [DIV_W-1:0] baud_div,
  output logic             half_hit,
  output logic             full_hit
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_min;

  // Very short bit periods would leave no room for a half-bit start check.
  assign div_min = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q <= DIV_W'(MIN_DIV);
    end else if (load) begin
      div_q <= div_min;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign half_hit = (cnt == (div_q >> 1));
  assign full_hit = (cnt == div_q);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, mid-bit sampling, optional parity,
// stop check and a single-entry holding register with valid/ready handoff.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level while enabled
// START  | confirming the start bit at its midpoint
// DATA   | sampling data bits LSB first at each bit midpoint
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then committing the frame
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int DIV_W     = DEF_DIV_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int IDX_W = idx_width(DATA_BITS);

  rx_state_e state_q;
  rx_state_e state_nx;

  logic                 rx_meta;
  logic                 rx_s;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 perr;
  logic                 last_bit;
  logic                 hold_free;

  logic timer_load;
  logic timer_clear;
  logic half_hit;
  logic full_hit;
  logic start_data;
  logic shift_en;
  logic parity_smp;
  logic commit;

  // rx_in is asynchronous to clock; idle level is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  uart_bit_timer #(
    .DIV_W(DIV_W)
  ) u_bit_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .clear    (timer_clear),
    .baud_div (baud_div),
    .half_hit (half_hit),
    .full_hit (full_hit)
  );

  assign last_bit = (bit_idx == IDX_W'(DATA_BITS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state_q;
    timer_load  = 1'b0;
    timer_clear = 1'b0;
    start_data  = 1'b0;
    shift_en    = 1'b0;
    parity_smp  = 1'b0;
    commit      = 1'b0;
    if (state_q != IDLE && !rx_en) begin
      state_nx    = IDLE;
      timer_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          timer_clear = 1'b1;
          if (rx_en && !rx_s) begin
            state_nx   = START;
            timer_load = 1'b1;
          end
        end
        START: begin
          if (half_hit) begin
            timer_clear = 1'b1;
            if (rx_s) begin
              state_nx = IDLE;
            end else begin
              state_nx   = DATA;
              start_data = 1'b1;
            end
          end
        end
        DATA: begin
          if (full_hit) begin
            timer_clear = 1'b1;
            shift_en    = 1'b1;
            if (last_bit) begin
              state_nx = parity_en ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (full_hit) begin
            timer_clear = 1'b1;
            parity_smp  = 1'b1;
            state_nx    = STOP;
          end
        end
        STOP: begin
          // Leaving at mid stop bit lets the next start edge be caught.
          if (full_hit) begin
            timer_clear = 1'b1;
            commit      = 1'b1;
            state_nx    = IDLE;
          end
        end
        default: begin
          state_nx    = IDLE;
          timer_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_idx <= '0;
      perr    <= 1'b0;
    end else begin
      if (start_data) begin
        bit_idx <= '0;
        perr    <= 1'b0;
      end
      if (shift_en) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        if (!last_bit) begin
          bit_idx <= bit_idx + 1'b1;
        end
      end
      if (parity_smp) begin
        perr <= rx_s ^ (^shreg) ^ parity_odd;
      end
    end
  end

  assign hold_free = !rx_valid || rx_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= commit && !hold_free;
      if (commit && hold_free) begin
        rx_data    <= shreg;
        rx_valid   <= 1'b1;
        frame_err  <= ~rx_s;
        parity_err <= perr;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames plus randomized frames checked
// against a frame-level model of what each transmitted frame should yield.
module tb_uart_rx_ctrl;

  localparam int DATA_BITS = 8;
  localparam int DIV_W     = 16;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 rx_en = 1'b0;
  logic [DIV_W-1:0]     baud_div = 16'd9;
  logic                 parity_en = 1'b0;
  logic                 parity_odd = 1'b0;
  logic                 rx_in = 1'b1;
  logic                 rx_ready = 1'b0;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];
  int   head      = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   ovr_cnt   = 0;
  int   ovr_exp   = 0;
  int   valid_cyc = 0;
  int   start_cyc = 0;
  bit   rand_ready = 1'b0;

  uart_rx_ctrl #(
    .DATA_BITS(DATA_BITS),
    .DIV_W    (DIV_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_en     (rx_en),
    .baud_div  (baud_div),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Even parity: data plus parity bit carry an even number of ones.
  function automatic logic exp_perr(logic [7:0] d, bit pen, bit odd, bit pbit);
    int ones;
    ones = $countones(d) + int'(pbit);
    return pen && (((ones % 2) == 0) == odd);
  endfunction

  function automatic int period(input int div);
    return ((div < 3) ? 3 : div) + 1;
  endfunction

  // One clock: observe outputs at the falling edge, then move past the rising edge.
  task automatic tick();
    @(negedge clock);
    if (overrun) ovr_cnt++;
    if (reset && rx_valid) begin
      if (head >= exp_q.size()) begin
        chk("unexp_valid", 32'(rx_valid), 32'd0);
      end else begin
        chk("rx_data", 32'(rx_data), 32'(exp_q[head].d));
        chk("frame_err", 32'(frame_err), 32'(exp_q[head].fe));
        chk("parity_err", 32'(parity_err), 32'(exp_q[head].pe));
        if (rx_ready) begin
          head++;
          valid_cyc = cyc;
        end
      end
    end
    cyc++;
    @(posedge clock);
    #1;
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit with_par, input bit par_bit,
                            input bit stop_lvl, input int p, input bit scramble, input int cut);
    logic [11:0] fb;
    int nb;
    int n;
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = d[i];
    nb = 9;
    if (with_par) begin
      fb[nb] = par_bit;
      nb++;
    end
    fb[nb] = stop_lvl;
    nb++;
    n = 0;
    start_cyc = cyc;
    for (int b = 0; b < nb; b++) begin
      rx_in = fb[b];
      for (int k = 0; k < p; k++) begin
        if (cut > 0 && n == cut) begin
          rx_in = 1'b1;
          return;
        end
        tick();
        n++;
        if (scramble && n == p) baud_div = DIV_W'($urandom_range(0, 40));
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic expect_frame(input logic [7:0] d, input bit pen, input bit odd,
                              input bit pbit, input bit stop_lvl);
    exp_t e;
    e.d  = d;
    e.fe = ~stop_lvl;
    e.pe = exp_perr(d, pen, odd, pbit);
    exp_q.push_back(e);
  endtask

  initial begin
    int p;
    int lat;
    int h0;
    bit saw_busy;
    bit busy_low;

    idle(3);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    rx_en = 1'b1;
    rx_ready = 1'b1;
    idle(5);

    // 8N1 byte with latency window
    p = period(9);
    expect_frame(8'hA5, 0, 0, 0, 1);
    send_frame(8'hA5, 0, 0, 1, p, 0, 0);
    idle(2 * p);
    chk("a5_received", 32'(head), 32'd1);
    lat = valid_cyc - start_cyc;
    chk("a5_latency_in_window", 32'(lat >= 96 && lat <= 100), 32'd1);

    // glitch shorter than half a bit
    h0 = head;
    saw_busy = 0;
    busy_low = 0;
    rx_in = 1'b0;
    idle(3);
    rx_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (busy) saw_busy = 1;
      if (saw_busy && !busy) begin
        busy_low = 1;
        break;
      end
      tick();
    end
    chk("false_start_busy_seen", 32'(saw_busy), 32'd1);
    chk("false_start_busy_clear", 32'(busy_low), 32'd1);
    idle(p);
    chk("false_start_no_frame", 32'(head), 32'(h0));

    // even parity, bad then good parity bit
    parity_en = 1'b1;
    parity_odd = 1'b0;
    expect_frame(8'h03, 1, 0, 1, 1);
    send_frame(8'h03, 1, 1, 1, p, 0, 0);
    idle(2 * p);
    expect_frame(8'h03, 1, 0, 0, 1);
    send_frame(8'h03, 1, 0, 1, p, 0, 0);
    idle(2 * p);
    chk("parity_frames", 32'(head), 32'(h0 + 2));

    // low stop bit
    parity_en = 1'b0;
    expect_frame(8'h5A, 0, 0, 0, 0);
    send_frame(8'h5A, 0, 0, 0, p, 0, 0);
    idle(3 * p);
    chk("stop_low_frame", 32'(head), 32'(h0 + 3));

    // overrun: consumer stalled across two back-to-back frames
    rx_ready = 1'b0;
    expect_frame(8'h11, 0, 0, 0, 1);
    send_frame(8'h11, 0, 0, 1, p, 0, 0);
    send_frame(8'h22, 0, 0, 1, p, 0, 0);
    ovr_exp++;
    idle(2 * p);
    chk("overrun_pulses", 32'(ovr_cnt), 32'(ovr_exp));
    chk("overrun_held_valid", 32'(rx_valid), 32'd1);
    chk("overrun_held_data", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    tick();
    chk("release_valid_drop", 32'(rx_valid), 32'd0);
    chk("overrun_consumed", 32'(head), 32'(h0 + 4));

    // receiver disabled mid-byte
    h0 = head;
    send_frame(8'hFF, 0, 0, 1, p, 0, 4 * p + p / 2);
    rx_en = 1'b0;
    tick();
    chk("disable_busy", 32'(busy), 32'd0);
    rx_en = 1'b1;
    idle(3 * p);
    chk("disable_no_frame", 32'(head), 32'(h0));

    // reset mid-frame
    send_frame(8'h0F, 0, 0, 1, p, 0, 5 * p);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(rx_valid), 32'd0);
    chk("midrst_data", 32'(rx_data), 32'd0);
    idle(2);
    reset = 1'b1;
    idle(3 * p);
    chk("midrst_no_frame", 32'(head), 32'(h0));

    expect_frame(8'hC3, 0, 0, 0, 1);
    send_frame(8'hC3, 0, 0, 1, p, 0, 0);
    idle(2 * p);
    chk("c3_after_abort", 32'(head), 32'(h0 + 1));

    // randomized frames, divisors including clamped ones, random consumer
    rand_ready = 1'b1;
    for (int f = 0; f < 16; f++) begin
      int   div;
      logic [7:0] d;
      bit   pen, odd, pbit, stop_lvl, scr;
      div = $urandom_range(0, 12);
      d = 8'($urandom_range(0, 255));
      pen = 1'($urandom_range(0, 1));
      odd = 1'($urandom_range(0, 1));
      pbit = (^d) ^ odd ^ 1'($urandom_range(0, 1));
      stop_lvl = ($urandom_range(0, 3) != 0);
      scr = 1'($urandom_range(0, 1));
      baud_div = DIV_W'(div);
      parity_en = pen;
      parity_odd = odd;
      p = period(div);
      expect_frame(d, pen, odd, pbit, stop_lvl);
      send_frame(d, pen, pbit, stop_lvl, p, scr, 0);
      idle(3 * p + 4);
    end
    rand_ready = 1'b0;
    rx_ready = 1'b1;
    idle(10);

    chk("all_frames_seen", 32'(head), 32'(exp_q.size()));
    chk("overrun_total", 32'(ovr_cnt), 32'(ovr_exp));
    chk("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
